// File: rtl/jtdd_pal_dma.sv
// Palette DMA: copies PAL_LEN bytes from source memory into the colour-mixer palette port, one byte per WRITE/HOLD pair.
// Latency: source read latency + 3 cycles per byte; done pulses one cycle after the last HOLD.
// Backpressure: waits on mem_ok, pauses in WAITVB during active video or CPU access; CPU is stalled only during WRITE/HOLD.
module jtdd_pal_dma #(
    parameter int unsigned PAL_LEN      = 1024,
    parameter bit          ALLOW_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       LVBL,
    output logic       mem_cs,
    output logic [9:0] mem_addr,
    input  logic       mem_ok,
    input  logic [7:0] mem_data,
    input  logic       cpu_pal_cs,
    input  logic [9:0] cpu_AB,
    input  logic [7:0] cpu_dout,
    output logic       cpu_wait,
    output logic       pal_cs,
    output logic [9:0] pal_AB,
    output logic [7:0] pal_din,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, FETCH, WAITVB, WRITE, HOLD} state_t;

    localparam logic [9:0] LAST = 10'(PAL_LEN - 1);

    state_t     state, state_nxt;
    logic [9:0] cnt, cnt_nxt, addr_nxt;
    logic [7:0] data, data_nxt;
    logic       pending, pending_nxt;
    logic       cs_nxt, busy_nxt, done_nxt;
    logic       dma_port;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data     <= '0;
            pending  <= 1'b0;
            mem_cs   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            data     <= data_nxt;
            pending  <= pending_nxt;
            mem_cs   <= cs_nxt;
            mem_addr <= addr_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        addr_nxt    = mem_addr;
        data_nxt    = data;
        pending_nxt = pending;
        cs_nxt      = mem_cs;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        // A start outside IDLE (including the final HOLD) queues one more transfer
        if (state != IDLE && start) pending_nxt = 1'b1;
        case (state)
            IDLE: begin
                if (start || pending) begin
                    state_nxt   = FETCH;
                    cnt_nxt     = '0;
                    addr_nxt    = '0;
                    cs_nxt      = 1'b1;
                    busy_nxt    = 1'b1;
                    pending_nxt = 1'b0;
                end
            end
            FETCH: begin
                if (mem_ok) begin
                    data_nxt  = mem_data;
                    cs_nxt    = 1'b0;
                    state_nxt = WAITVB;
                end
            end
            WAITVB: begin
                if ((!LVBL || ALLOW_ACTIVE) && !cpu_pal_cs) state_nxt = WRITE;
            end
            WRITE: state_nxt = HOLD;
            HOLD: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + 10'd1;
                    addr_nxt  = cnt + 10'd1;
                    cs_nxt    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The mixer latches its write enable a cycle late, so address/data stay owned by the DMA through HOLD
    assign dma_port = (state == WRITE) || (state == HOLD);
    assign pal_cs   = dma_port ? (state == WRITE) : cpu_pal_cs;
    assign pal_AB   = dma_port ? cnt  : cpu_AB;
    assign pal_din  = dma_port ? data : cpu_dout;
    assign cpu_wait = dma_port && cpu_pal_cs;

endmodule

// File: tb/tb_jtdd_pal_dma.sv
// Bench for jtdd_pal_dma with PAL_LEN=4: a randomized source memory and a negedge monitor
// record palette writes, which each scenario compares against the expected byte list.
module tb_jtdd_pal_dma;
    localparam int PAL_LEN = 4;

    logic       clk = 1'b0;
    logic       rst, start, LVBL, mem_cs, mem_ok, cpu_pal_cs, cpu_wait, pal_cs, busy, done;
    logic [9:0] mem_addr, cpu_AB, pal_AB;
    logic [7:0] mem_data, cpu_dout, pal_din;

    int total = 0;
    int bad   = 0;

    logic [7:0]  src [PAL_LEN];
    int          mem_lat = 0;
    logic [17:0] wr_q[$];
    int done_cnt = 0, memcs_cnt = 0, lvbl_viol = 0, cpu_viol = 0, hold_viol = 0, addr_viol = 0;
    logic        lvbl_e = 1'b0, cpu_e = 1'b0;
    logic        prev_wr = 1'b0;
    logic [9:0]  prev_ab = '0;
    logic [7:0]  prev_din = '0;

    always #5 clk = ~clk;

    jtdd_pal_dma #(.PAL_LEN(PAL_LEN), .ALLOW_ACTIVE(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .LVBL(LVBL),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_ok(mem_ok), .mem_data(mem_data),
        .cpu_pal_cs(cpu_pal_cs), .cpu_AB(cpu_AB), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .pal_cs(pal_cs), .pal_AB(pal_AB), .pal_din(pal_din), .busy(busy), .done(done)
    );

    // Source memory: answers each request mem_lat cycles later (1..3 at random when mem_lat is 0)
    initial begin : mem_model
        int lat;
        mem_ok = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ok = 1'b0;
            if (mem_cs) begin
                lat = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 3));
                repeat (lat - 1) begin
                    @(posedge clk);
                    #1;
                end
                mem_ok = 1'b1;
                mem_data = src[mem_addr];
            end
        end
    end

    always @(posedge clk) begin
        lvbl_e <= LVBL;
        cpu_e  <= cpu_pal_cs;
    end

    // DMA writes are the palette strobes aimed below PAL_LEN; CPU traffic always uses higher addresses
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_cs) begin
            memcs_cnt++;
            if (mem_addr >= PAL_LEN) addr_viol++;
        end
        if (prev_wr) begin
            if (pal_cs || pal_AB != prev_ab || pal_din != prev_din) hold_viol++;
            prev_wr = 1'b0;
        end else if (pal_cs && pal_AB < PAL_LEN) begin
            wr_q.push_back({pal_AB, pal_din});
            if (lvbl_e) lvbl_viol++;
            if (cpu_e) cpu_viol++;
            prev_wr = 1'b1;
            prev_ab = pal_AB;
            prev_din = pal_din;
        end
    end

    function automatic logic [17:0] exp_wr(input int k);
        return {10'(k % PAL_LEN), src[k % PAL_LEN]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cycles++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic rand_src();
        for (int i = 0; i < PAL_LEN; i++) src[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_pal_cs = 1'b0;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL reset_mem_cs got=%b want=0", mem_cs); end
        total++; if (mem_addr !== 10'd0) begin bad++; $display("FAIL reset_mem_addr got=%0d want=0", mem_addr); end
        total++; if (cpu_wait !== 1'b0) begin bad++; $display("FAIL reset_cpu_wait got=%b want=0", cpu_wait); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_pal_cs = 1'($urandom_range(0, 1));
            cpu_AB = 10'($urandom_range(512, 1023));
            cpu_dout = 8'($urandom);
            #1;
            total++; if (pal_cs !== cpu_pal_cs) begin bad++; $display("FAIL idle_pal_cs got=%b want=%b", pal_cs, cpu_pal_cs); end
            total++; if (pal_AB !== cpu_AB) begin bad++; $display("FAIL idle_pal_AB got=%h want=%h", pal_AB, cpu_AB); end
            total++; if (pal_din !== cpu_dout) begin bad++; $display("FAIL idle_pal_din got=%h want=%h", pal_din, cpu_dout); end
            tick();
        end
        cpu_pal_cs = 1'b0;
        cpu_AB = 10'h3F0;
    endtask

    task automatic test_basic();
        int d0, cyc;
        bit ok;
        mem_lat = 2;
        for (int i = 0; i < PAL_LEN; i++) src[i] = 8'(i + 16);
        LVBL = 1'b0;
        wr_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
        total++; if (cyc != (mem_lat + 3) * PAL_LEN) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", cyc, (mem_lat + 3) * PAL_LEN); end
        tick();
        total++; if (wr_q.size() != PAL_LEN) begin bad++; $display("FAIL basic_nwr got=%0d want=%0d", wr_q.size(), PAL_LEN); end
        for (int i = 0; i < PAL_LEN && i < wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_wr(i)) begin bad++; $display("FAIL basic_wr%0d got=%h want=%h", i, wr_q[i], exp_wr(i)); end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=1", done_cnt - d0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy); end
        total++; if (lvbl_viol + cpu_viol + hold_viol + addr_viol != 0) begin bad++; $display("FAIL basic_protocol got=%0d/%0d/%0d/%0d want=0", lvbl_viol, cpu_viol, hold_viol, addr_viol); end
        mem_lat = 0;
    endtask

    task automatic test_vblank_pause();
        int d0, cyc;
        bit ok;
        rand_src();
        LVBL = 1'b0;
        wr_q.delete();
        d0 = done_cnt;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_cs && mem_addr == 10'd1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL vb_fetch1_timeout got=none want=fetch_of_byte1"); end
        LVBL = 1'b1;
        repeat (12) tick();
        total++; if (wr_q.size() != 1) begin bad++; $display("FAIL vb_paused_writes got=%0d want=1", wr_q.size()); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL vb_paused_busy got=%b want=1", busy); end
        total++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL vb_paused_mem_cs got=%b want=0", mem_cs); end
        LVBL = 1'b0;
        wait_done(200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL vb_timeout got=no_done want=done"); end
        tick();
        total++; if (wr_q.size() != PAL_LEN) begin bad++; $display("FAIL vb_nwr got=%0d want=%0d", wr_q.size(), PAL_LEN); end
        for (int i = 0; i < PAL_LEN && i < wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_wr(i)) begin bad++; $display("FAIL vb_wr%0d got=%h want=%h", i, wr_q[i], exp_wr(i)); end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL vb_done_cnt got=%0d want=1", done_cnt - d0); end
        total++; if (lvbl_viol + cpu_viol + hold_viol + addr_viol != 0) begin bad++; $display("FAIL vb_protocol got=%0d/%0d/%0d/%0d want=0", lvbl_viol, cpu_viol, hold_viol, addr_viol); end
    endtask

    task automatic test_cpu_conflict();
        int d0, cyc;
        bit ok;
        logic [9:0] cab;
        rand_src();
        LVBL = 1'b0;
        wr_q.delete();
        d0 = done_cnt;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pal_cs) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL cpu_write_timeout got=none want=dma_write"); end
        cab = 10'h3F5;
        cpu_pal_cs = 1'b1;
        cpu_AB = cab;
        cpu_dout = 8'($urandom);
        #1;
        total++; if (cpu_wait !== 1'b1) begin bad++; $display("FAIL cpu_wait_write got=%b want=1", cpu_wait); end
        total++; if (pal_cs !== 1'b1 || pal_AB !== 10'd0 || pal_din !== src[0]) begin bad++; $display("FAIL cpu_port_write got=%b/%h/%h want=1/000/%h", pal_cs, pal_AB, pal_din, src[0]); end
        tick();
        total++; if (cpu_wait !== 1'b1) begin bad++; $display("FAIL cpu_wait_hold got=%b want=1", cpu_wait); end
        total++; if (pal_cs !== 1'b0 || pal_AB !== 10'd0 || pal_din !== src[0]) begin bad++; $display("FAIL cpu_port_hold got=%b/%h/%h want=0/000/%h", pal_cs, pal_AB, pal_din, src[0]); end
        tick();
        total++; if (cpu_wait !== 1'b0) begin bad++; $display("FAIL cpu_wait_fetch got=%b want=0", cpu_wait); end
        total++; if (pal_cs !== 1'b1 || pal_AB !== cab) begin bad++; $display("FAIL cpu_fwd_fetch got=%b/%h want=1/%h", pal_cs, pal_AB, cab); end
        repeat (10) tick();
        total++; if (wr_q.size() != 1) begin bad++; $display("FAIL cpu_deferred_writes got=%0d want=1", wr_q.size()); end
        total++; if (pal_AB !== cab || pal_din !== cpu_dout || cpu_wait !== 1'b0) begin bad++; $display("FAIL cpu_fwd_waitvb got=%h/%h/%b want=%h/%h/0", pal_AB, pal_din, cpu_wait, cab, cpu_dout); end
        cpu_pal_cs = 1'b0;
        wait_done(200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL cpu_timeout got=no_done want=done"); end
        tick();
        total++; if (wr_q.size() != PAL_LEN) begin bad++; $display("FAIL cpu_nwr got=%0d want=%0d", wr_q.size(), PAL_LEN); end
        for (int i = 0; i < PAL_LEN && i < wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_wr(i)) begin bad++; $display("FAIL cpu_wr%0d got=%h want=%h", i, wr_q[i], exp_wr(i)); end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL cpu_done_cnt got=%0d want=1", done_cnt - d0); end
        total++; if (lvbl_viol + cpu_viol + hold_viol + addr_viol != 0) begin bad++; $display("FAIL cpu_protocol got=%0d/%0d/%0d/%0d want=0", lvbl_viol, cpu_viol, hold_viol, addr_viol); end
    endtask

    task automatic test_back_to_back();
        int d0, cyc;
        bit ok;
        rand_src();
        LVBL = 1'b0;
        wr_q.delete();
        d0 = done_cnt;
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_done(200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout got=no_done want=done"); end
        tick();
        total++; if (mem_cs !== 1'b1 || mem_addr !== 10'd0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b/%0d/%b want=1/0/1", mem_cs, mem_addr, busy); end
        wait_done(200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_second_timeout got=no_done want=done"); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (mem_cs !== 1'b1 || mem_addr !== 10'd0) begin bad++; $display("FAIL b2b_coincident got=%b/%0d want=1/0", mem_cs, mem_addr); end
        wait_done(200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_third_timeout got=no_done want=done"); end
        repeat (20) tick();
        total++; if (busy !== 1'b0 || mem_cs !== 1'b0) begin bad++; $display("FAIL b2b_settled got=%b/%b want=0/0", busy, mem_cs); end
        total++; if (done_cnt - d0 != 3) begin bad++; $display("FAIL b2b_done_cnt got=%0d want=3", done_cnt - d0); end
        total++; if (wr_q.size() != 3 * PAL_LEN) begin bad++; $display("FAIL b2b_nwr got=%0d want=%0d", wr_q.size(), 3 * PAL_LEN); end
        for (int k = 0; k < 3 * PAL_LEN && k < wr_q.size(); k++) begin
            total++; if (wr_q[k] !== exp_wr(k)) begin bad++; $display("FAIL b2b_wr%0d got=%h want=%h", k, wr_q[k], exp_wr(k)); end
        end
    endtask

    task automatic test_reset_mid();
        int d0, m0, w0, cyc;
        bit ok;
        rand_src();
        LVBL = 1'b0;
        wr_q.delete();
        d0 = done_cnt;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pal_cs && pal_AB == 10'd2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL rmid_write2_timeout got=none want=write_of_byte2"); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || cpu_wait !== 1'b0) begin bad++; $display("FAIL rmid_flags got=%b/%b/%b want=0/0/0", busy, done, cpu_wait); end
        total++; if (mem_cs !== 1'b0 || mem_addr !== 10'd0) begin bad++; $display("FAIL rmid_mem got=%b/%0d want=0/0", mem_cs, mem_addr); end
        total++; if (pal_AB !== cpu_AB || pal_cs !== cpu_pal_cs) begin bad++; $display("FAIL rmid_passthru got=%h want=%h", pal_AB, cpu_AB); end
        m0 = memcs_cnt;
        w0 = wr_q.size();
        repeat (20) tick();
        total++; if (done_cnt != d0) begin bad++; $display("FAIL rmid_no_done got=%0d want=%0d", done_cnt, d0); end
        total++; if (memcs_cnt != m0 || wr_q.size() != w0) begin bad++; $display("FAIL rmid_abandoned got=%0d/%0d want=%0d/%0d", memcs_cnt, wr_q.size(), m0, w0); end
        wr_q.delete();
        pulse_start();
        wait_done(200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_restart_timeout got=no_done want=done"); end
        tick();
        total++; if (wr_q.size() != PAL_LEN) begin bad++; $display("FAIL rmid_nwr got=%0d want=%0d", wr_q.size(), PAL_LEN); end
        for (int i = 0; i < PAL_LEN && i < wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_wr(i)) begin bad++; $display("FAIL rmid_wr%0d got=%h want=%h", i, wr_q[i], exp_wr(i)); end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rmid_done_cnt got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_random();
        int d0;
        bit ok;
        for (int it = 0; it < 3; it++) begin
            rand_src();
            wr_q.delete();
            d0 = done_cnt;
            pulse_start();
            ok = 1'b0;
            for (int c = 0; c < 600; c++) begin
                if (done) begin
                    ok = 1'b1;
                    break;
                end
                LVBL = ($urandom_range(0, 3) == 0);
                cpu_pal_cs = ($urandom_range(0, 4) == 0);
                cpu_AB = 10'($urandom_range(1000, 1023));
                cpu_dout = 8'($urandom);
                tick();
            end
            LVBL = 1'b0;
            cpu_pal_cs = 1'b0;
            total++; if (!ok) begin bad++; $display("FAIL rnd%0d_timeout got=no_done want=done", it); end
            tick();
            total++; if (wr_q.size() != PAL_LEN) begin bad++; $display("FAIL rnd%0d_nwr got=%0d want=%0d", it, wr_q.size(), PAL_LEN); end
            for (int i = 0; i < PAL_LEN && i < wr_q.size(); i++) begin
                total++; if (wr_q[i] !== exp_wr(i)) begin bad++; $display("FAIL rnd%0d_wr%0d got=%h want=%h", it, i, wr_q[i], exp_wr(i)); end
            end
            total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rnd%0d_done_cnt got=%0d want=1", it, done_cnt - d0); end
            total++; if (lvbl_viol + cpu_viol + hold_viol + addr_viol != 0) begin bad++; $display("FAIL rnd%0d_protocol got=%0d/%0d/%0d/%0d want=0", it, lvbl_viol, cpu_viol, hold_viol, addr_viol); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        LVBL = 1'b0;
        cpu_pal_cs = 1'b0;
        cpu_AB = 10'h3F0;
        cpu_dout = 8'h00;
        test_reset();
        test_basic();
        test_vblank_pause();
        test_cpu_conflict();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
